dma_cmd_arbiter: RTL and testbench

Shares one `dma_engine` command port between `NUM_REQ` requesters, such as per-tile controllers or the global scheduler. It selects one pending 128-bit DMA command by round-robin, registers it, and issues it with a valid/ready handshake. It keeps exactly one command outstanding and routes the engine's `cmd_done` pulse back to the requester that owns the command. It sits directly in front of `dma_engine.cmd/cmd_valid/cmd_ready/cmd_done` and forwards commands unmodified.

---
 rtl/dma_cmd_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dma_cmd_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dma_cmd_arbiter
// Description : Round-robin arbiter that shares one DMA engine command port
//               between NUM_REQ requesters. One command is outstanding at a
//               time. The engine's completion pulse is routed back to the
//               requester that owns the command. A watchdog flags an engine
//               that never reports completion.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             in   sole clock, all logic on posedge
//   rst_n           in   synchronous active-low reset
//   i_req_cmd       in   NUM_REQ*CMD_W, requester i at [i*CMD_W +: CMD_W]
//   i_req_valid     in   NUM_REQ, command pending per requester
//   o_req_ready     out  NUM_REQ, accept strobe (at most one bit high)
//   o_req_done      out  NUM_REQ, one-cycle completion pulse to owner
//   o_dma_cmd       out  CMD_W, registered command to the engine
//   o_dma_cmd_valid out  command valid to the engine
//   i_dma_cmd_ready in   engine accepts the command
//   i_dma_cmd_done  in   engine completion pulse
//   o_busy          out  high whenever the arbiter is not idle
//   o_owner         out  ID_W, current or last granted requester
//   o_timeout_err   out  sticky watchdog flag
//   i_err_clr       in   clears o_timeout_err (a simultaneous set wins)
// ============================================================================
module dma_cmd_arbiter #(
  parameter  int          NUM_REQ        = 4,
  parameter  int          CMD_W          = 128,
  parameter  int unsigned TIMEOUT_CYCLES = 65535,
  localparam int          ID_W           = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ*CMD_W-1:0] i_req_cmd,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  output logic [NUM_REQ-1:0]       o_req_ready,
  output logic [NUM_REQ-1:0]       o_req_done,
  output logic [CMD_W-1:0]         o_dma_cmd,
  output logic                     o_dma_cmd_valid,
  input  logic                     i_dma_cmd_ready,
  input  logic                     i_dma_cmd_done,
  output logic                     o_busy,
  output logic [ID_W-1:0]          o_owner,
  output logic                     o_timeout_err,
  input  logic                     i_err_clr
);

  localparam logic [31:0]     C_TIMEOUT    = 32'(TIMEOUT_CYCLES);
  localparam bit              C_WD_EN      = (TIMEOUT_CYCLES != 0);
  localparam logic [ID_W-1:0] C_LAST_RESET = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_W-1:0]     r_last_owner;
  logic [ID_W-1:0]     r_owner;
  logic [CMD_W-1:0]    r_cmd;
  logic [NUM_REQ-1:0]  r_done;
  logic [31:0]         r_wd;
  logic                r_timeout_err;

  logic                w_grant_vld;
  logic [ID_W-1:0]     w_grant_idx;
  logic [NUM_REQ-1:0]  w_grant_onehot;
  logic [NUM_REQ-1:0]  w_owner_onehot;
  logic [CMD_W-1:0]    w_sel_cmd;
  logic                w_wd_hit;

  // Index base+off modulo NUM_REQ, for off in 1..NUM_REQ.
  function automatic logic [ID_W-1:0] f_wrap(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[ID_W-1:0];
  endfunction

  // Round-robin search starting just after the last owner, wrapping around.
  // The last owner itself is examined last, so it only wins when alone.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_grant_vld && i_req_valid[f_wrap(r_last_owner, k)]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = f_wrap(r_last_owner, k);
      end
    end
  end

  always_comb begin
    w_grant_onehot = '0;
    if (w_grant_vld) w_grant_onehot[w_grant_idx] = 1'b1;
    w_owner_onehot = '0;
    w_owner_onehot[r_owner] = 1'b1;
  end

  assign w_sel_cmd = i_req_cmd[w_grant_idx*CMD_W +: CMD_W];

  // Counter equals the number of full cycles already spent in WAIT_DONE,
  // so the flag rises one cycle after it reaches the limit.
  assign w_wd_hit = C_WD_EN && (r_state == S_WAIT_DONE) && (r_wd == C_TIMEOUT);

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_grant_vld)     w_state_nxt = S_ISSUE;
      S_ISSUE:     if (i_dma_cmd_ready) w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (i_dma_cmd_done)  w_state_nxt = S_IDLE;
      default:                          w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_last_owner  <= C_LAST_RESET;
      r_owner       <= '0;
      r_cmd         <= '0;
      r_done        <= '0;
      r_wd          <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= '0;

      if ((r_state == S_IDLE) && w_grant_vld) begin
        r_cmd        <= w_sel_cmd;
        r_owner      <= w_grant_idx;
        r_last_owner <= w_grant_idx;
      end

      if ((r_state == S_WAIT_DONE) && i_dma_cmd_done) r_done <= w_owner_onehot;

      // Held at zero outside WAIT_DONE so entry always starts from zero;
      // saturates so the limit can only be matched once per wait.
      if (r_state != S_WAIT_DONE) r_wd <= '0;
      else if (r_wd != '1)        r_wd <= r_wd + 32'd1;

      if (w_wd_hit)       r_timeout_err <= 1'b1;
      else if (i_err_clr) r_timeout_err <= 1'b0;
    end
  end

  assign o_req_ready     = (r_state == S_IDLE) ? w_grant_onehot : '0;
  assign o_req_done      = r_done;
  assign o_dma_cmd       = r_cmd;
  assign o_dma_cmd_valid = (r_state == S_ISSUE);
  assign o_busy          = (r_state != S_IDLE);
  assign o_owner         = r_owner;
  assign o_timeout_err   = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_dma_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_cmd_arbiter
// Description : Directed self-checking bench for dma_cmd_arbiter (4 requesters,
//               128-bit commands, watchdog limit 20).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_cmd_arbiter;

  localparam int NR = 4;
  localparam int CW = 128;
  localparam int TO = 20;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR*CW-1:0] req_cmd;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    req_done;
  logic [CW-1:0]    dma_cmd;
  logic             dma_cmd_valid;
  logic             dma_cmd_ready;
  logic             dma_cmd_done;
  logic             busy;
  logic [1:0]       owner;
  logic             timeout_err;
  logic             err_clr;

  int tests_run    = 0;
  int tests_failed = 0;
  int hs_cnt       = 0;

  dma_cmd_arbiter #(.NUM_REQ(NR), .CMD_W(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_req_cmd       (req_cmd),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .o_req_done      (req_done),
    .o_dma_cmd       (dma_cmd),
    .o_dma_cmd_valid (dma_cmd_valid),
    .i_dma_cmd_ready (dma_cmd_ready),
    .i_dma_cmd_done  (dma_cmd_done),
    .o_busy          (busy),
    .o_owner         (owner),
    .o_timeout_err   (timeout_err),
    .i_err_clr       (err_clr)
  );

  always #5 clk = ~clk;

  // Engine-side handshake counter
  always @(posedge clk) if (rst_n && dma_cmd_valid && dma_cmd_ready) hs_cnt <= hs_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish within 2 ms");
    $fatal(1, "bench timed out");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_cmd(input int r, input logic [CW-1:0] v);
    req_cmd[r*CW +: CW] = v;
  endtask

  function automatic logic [CW-1:0] mk_cmd(input int r, input int tag);
    return {32'(r), 32'(tag), 64'hDEAD_BEEF_0BAD_F00D};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; req_cmd = '0;
    dma_cmd_ready = 1'b1; dma_cmd_done = 1'b0; err_clr = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(); #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests_run++; if (dma_cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b want 0", dma_cmd_valid); end
    tests_run++; if (dma_cmd !== '0) begin tests_failed++; $display("FAIL rst_cmd: got %h want 0", dma_cmd); end
    tests_run++; if (owner !== 2'd0) begin tests_failed++; $display("FAIL rst_owner: got %0d want 0", owner); end
    tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
    tests_run++; if (req_done !== 4'b0000) begin tests_failed++; $display("FAIL rst_done: got %b want 0000", req_done); end
    tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL rst_err: got %b want 0", timeout_err); end
  endtask

  task automatic test_single();
    logic [CW-1:0] c1;
    c1 = 128'h03010000_00000000_00000000_00010002;
    do_reset();
    set_cmd(2, c1); req_valid = 4'b0100; #1;
    tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    tick(); req_valid = 4'b0000; #1;
    tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL single_ready_drop: got %b want 0000", req_ready); end
    tests_run++; if (dma_cmd_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid: got %b want 1", dma_cmd_valid); end
    tests_run++; if (dma_cmd !== c1) begin tests_failed++; $display("FAIL single_cmd: got %h want %h", dma_cmd, c1); end
    tests_run++; if (owner !== 2'd2) begin tests_failed++; $display("FAIL single_owner: got %0d want 2", owner); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy: got %b want 1", busy); end
    tick();
    tests_run++; if (dma_cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL single_wait_valid: got %b want 0", dma_cmd_valid); end
    tests_run++; if (req_done !== 4'b0000) begin tests_failed++; $display("FAIL single_early_done: got %b want 0000", req_done); end
    tick(9);
    dma_cmd_done = 1'b1; tick(); dma_cmd_done = 1'b0; #1;
    tests_run++; if (req_done !== 4'b0100) begin tests_failed++; $display("FAIL single_done: got %b want 0100", req_done); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_idle: got %b want 0", busy); end
    tick();
    tests_run++; if (req_done !== 4'b0000) begin tests_failed++; $display("FAIL single_done_pulse: got %b want 0000", req_done); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    for (int r = 0; r < NR; r++) set_cmd(r, mk_cmd(r, 7));
    req_valid = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      int g;
      g = n % NR;
      exp = 4'b0001 << g;
      #1;
      tests_run++; if (req_ready !== exp) begin tests_failed++; $display("FAIL rr_grant%0d: got %b want %b", n, req_ready, exp); end
      tick();
      tests_run++; if (owner !== g[1:0]) begin tests_failed++; $display("FAIL rr_owner%0d: got %0d want %0d", n, owner, g); end
      tests_run++; if (dma_cmd !== mk_cmd(g, 7)) begin tests_failed++; $display("FAIL rr_cmd%0d: got %h want %h", n, dma_cmd, mk_cmd(g, 7)); end
      tick(5);
      dma_cmd_done = 1'b1; tick(); dma_cmd_done = 1'b0;
      tests_run++; if (req_done !== exp) begin tests_failed++; $display("FAIL rr_done%0d: got %b want %b", n, req_done, exp); end
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_contention();
    do_reset();
    set_cmd(0, mk_cmd(0, 3)); set_cmd(1, mk_cmd(1, 3)); set_cmd(3, mk_cmd(3, 3));
    req_valid = 4'b0010; #1;
    tests_run++; if (req_ready !== 4'b0010) begin tests_failed++; $display("FAIL cont_grant1: got %b want 0010", req_ready); end
    tick(); req_valid = 4'b0000;
    tests_run++; if (owner !== 2'd1) begin tests_failed++; $display("FAIL cont_owner1: got %0d want 1", owner); end
    tick(); req_valid = 4'b1001;
    tick(2); #1;
    tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL cont_no_grant_wait: got %b want 0000", req_ready); end
    dma_cmd_done = 1'b1; tick(); dma_cmd_done = 1'b0; #1;
    tests_run++; if (req_done !== 4'b0010) begin tests_failed++; $display("FAIL cont_done1: got %b want 0010", req_done); end
    tests_run++; if (req_ready !== 4'b1000) begin tests_failed++; $display("FAIL cont_grant3: got %b want 1000", req_ready); end
    tick(); req_valid = 4'b0001;
    tests_run++; if (owner !== 2'd3) begin tests_failed++; $display("FAIL cont_owner3: got %0d want 3", owner); end
    tests_run++; if (dma_cmd !== mk_cmd(3, 3)) begin tests_failed++; $display("FAIL cont_cmd3: got %h want %h", dma_cmd, mk_cmd(3, 3)); end
    tick(3);
    dma_cmd_done = 1'b1; tick(); dma_cmd_done = 1'b0; #1;
    tests_run++; if (req_done !== 4'b1000) begin tests_failed++; $display("FAIL cont_done3: got %b want 1000", req_done); end
    tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL cont_grant0: got %b want 0001", req_ready); end
    tick(); req_valid = 4'b0000;
    tests_run++; if (owner !== 2'd0) begin tests_failed++; $display("FAIL cont_owner0: got %0d want 0", owner); end
    tick(2);
    dma_cmd_done = 1'b1; tick(); dma_cmd_done = 1'b0;
    tests_run++; if (req_done !== 4'b0001) begin tests_failed++; $display("FAIL cont_done0: got %b want 0001", req_done); end
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] ca, cb;
    int hs0;
    ca = mk_cmd(0, 'h11); cb = mk_cmd(0, 'h22);
    do_reset();
    dma_cmd_ready = 1'b0;
    set_cmd(0, ca); req_valid = 4'b0001; #1;
    tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL bp_grant: got %b want 0001", req_ready); end
    hs0 = hs_cnt;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (c == 0) begin req_valid = 4'b0000; set_cmd(0, cb); end
      #1;
      tests_run++; if (dma_cmd_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid%0d: got %b want 1", c, dma_cmd_valid); end
      tests_run++; if (dma_cmd !== ca) begin tests_failed++; $display("FAIL bp_cmd%0d: got %h want %h", c, dma_cmd, ca); end
    end
    tests_run++; if (hs_cnt - hs0 !== 0) begin tests_failed++; $display("FAIL bp_no_hs: got %0d want 0", hs_cnt - hs0); end
    tick(); dma_cmd_ready = 1'b1; #1;
    tests_run++; if (dma_cmd_valid !== 1'b1 || dma_cmd !== ca) begin tests_failed++; $display("FAIL bp_final: got valid %b cmd %h want 1 %h", dma_cmd_valid, dma_cmd, ca); end
    tick();
    tests_run++; if (dma_cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_valid_drop: got %b want 0", dma_cmd_valid); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL bp_busy: got %b want 1", busy); end
    tick(3);
    tests_run++; if (hs_cnt - hs0 !== 1) begin tests_failed++; $display("FAIL bp_one_hs: got %0d want 1", hs_cnt - hs0); end
    dma_cmd_done = 1'b1; tick(); dma_cmd_done = 1'b0;
    tests_run++; if (req_done !== 4'b0001) begin tests_failed++; $display("FAIL bp_done: got %b want 0001", req_done); end
  endtask

  task automatic test_watchdog();
    do_reset();
    set_cmd(2, mk_cmd(2, 'h55)); req_valid = 4'b0100; #1;
    tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("FAIL wd_grant: got %b want 0100", req_ready); end
    tick(); req_valid = 4'b0000;
    tick();                 // first WAIT_DONE cycle, counter 0
    tick(TO);               // counter equals the limit
    err_clr = 1'b1; #1;
    tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL wd_early: got %b want 0", timeout_err); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL wd_busy_pre: got %b want 1", busy); end
    tick(); err_clr = 1'b0; #1;
    tests_run++; if (timeout_err !== 1'b1) begin tests_failed++; $display("FAIL wd_set_wins: got %b want 1", timeout_err); end
    tests_run++; if (busy !== 1'b1 || dma_cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL wd_state: got busy %b valid %b want 1 0", busy, dma_cmd_valid); end
    tick(5);
    tests_run++; if (timeout_err !== 1'b1) begin tests_failed++; $display("FAIL wd_sticky: got %b want 1", timeout_err); end
    dma_cmd_done = 1'b1; tick(); dma_cmd_done = 1'b0;
    tests_run++; if (req_done !== 4'b0100) begin tests_failed++; $display("FAIL wd_done: got %b want 0100", req_done); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL wd_idle: got %b want 0", busy); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL wd_clear: got %b want 0", timeout_err); end
  endtask

  task automatic test_reset_spurious();
    do_reset();
    set_cmd(1, mk_cmd(1, 'h99)); req_valid = 4'b0010; #1;
    tests_run++; if (req_ready !== 4'b0010) begin tests_failed++; $display("FAIL rs_grant: got %b want 0010", req_ready); end
    tick(); req_valid = 4'b0000;
    tick(3);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rs_busy: got %b want 1", busy); end
    rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
    tests_run++; if (busy !== 1'b0 || dma_cmd_valid !== 1'b0) begin tests_failed++; $display("FAIL rs_state: got busy %b valid %b want 0 0", busy, dma_cmd_valid); end
    tests_run++; if (dma_cmd !== '0 || owner !== 2'd0) begin tests_failed++; $display("FAIL rs_regs: got cmd %h owner %0d want 0 0", dma_cmd, owner); end
    tests_run++; if (req_done !== 4'b0000 || req_ready !== 4'b0000 || timeout_err !== 1'b0) begin tests_failed++; $display("FAIL rs_outs: got done %b ready %b err %b want 0000 0000 0", req_done, req_ready, timeout_err); end
    dma_cmd_done = 1'b1; tick(); dma_cmd_done = 1'b0; #1;
    tests_run++; if (req_done !== 4'b0000 || busy !== 1'b0) begin tests_failed++; $display("FAIL rs_spurious: got done %b busy %b want 0000 0", req_done, busy); end
    tick();
    tests_run++; if (req_done !== 4'b0000) begin tests_failed++; $display("FAIL rs_spurious2: got %b want 0000", req_done); end
    // Priority pointer must be back at requester 0 first.
    req_valid = 4'b1010; #1;
    tests_run++; if (req_ready !== 4'b0010) begin tests_failed++; $display("FAIL rs_priority: got %b want 0010", req_ready); end
    req_valid = 4'b0000;
  endtask

  initial begin
    req_cmd = '0; req_valid = '0; dma_cmd_ready = 1'b1; dma_cmd_done = 1'b0; err_clr = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_contention();
    test_backpressure();
    test_watchdog();
    test_reset_spurious();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
